// File: rtl/divrep_pkg.sv
// Shared definitions for the repeated-subtraction divider.
//   - Controller state encoding (IDLE/RUN/DONE).
//   - Default widths for the dividend path and the divisor.
//   - State-decode helper used to build the busy flag.
// Optional feature macro used elsewhere in this slice: DIVREP_CYCLE_CNT_EN.
package divrep_pkg;

  localparam int NW_DEF = 16;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Any state other than IDLE means an operation is in flight or reporting.
  function automatic logic state_is_busy(input state_t s);
    state_is_busy = (s != S_IDLE);
  endfunction

endpackage

// File: rtl/repsub_divider_dp.sv
// Datapath of the repeated-subtraction divider.
// Holds the quotient counter Q, the remainder register R, the divisor register D
// and the divide-by-zero flag. It also provides the R>=D compare and the D==0 detect.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   i_load          capture the operands, clear Q and dz
//   i_sub           R <= R - D
//   i_inc           Q <= Q + 1
//   i_set_dz        dz <= 1, Q <= all-ones
//   i_dividend      operand loaded into R
//   i_divisor       operand loaded (zero-extended) into D
//   o_quotient      Q
//   o_remainder     R
//   o_dz            divide-by-zero flag
//   o_ge_d          R >= D (unsigned)
//   o_dzero         D == 0
module repsub_divider_dp
  import divrep_pkg::*;
#(
  parameter int NW = NW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_sub,
  input  logic          i_inc,
  input  logic          i_set_dz,
  input  logic [NW-1:0] i_dividend,
  input  logic [DW-1:0] i_divisor,
  output logic [NW-1:0] o_quotient,
  output logic [NW-1:0] o_remainder,
  output logic          o_dz,
  output logic          o_ge_d,
  output logic          o_dzero
);

  logic [NW-1:0] r_q;
  logic [NW-1:0] r_r;
  logic [NW-1:0] r_d;
  logic          r_dz;
  logic [NW-1:0] w_diff;

  // The controller only asserts i_sub when o_ge_d is true, so the
  // subtraction never wraps.
  assign w_diff  = r_r - r_d;
  assign o_ge_d  = (r_r >= r_d);
  assign o_dzero = (r_d == {NW{1'b0}});

  // Operand capture, iterative subtract/count and the divide-by-zero update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q  <= {NW{1'b0}};
      r_r  <= {NW{1'b0}};
      r_d  <= {NW{1'b0}};
      r_dz <= 1'b0;
    end else if (i_load) begin
      r_q  <= {NW{1'b0}};
      r_r  <= i_dividend;
      r_d  <= {{(NW-DW){1'b0}}, i_divisor};
      r_dz <= 1'b0;
    end else begin
      if (i_sub) begin
        r_r <= w_diff;
      end
      if (i_set_dz) begin
        r_dz <= 1'b1;
        r_q  <= {NW{1'b1}};
      end else if (i_inc) begin
        r_q <= r_q + {{(NW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign o_quotient  = r_q;
  assign o_remainder = r_r;
  assign o_dz        = r_dz;

endmodule

// File: rtl/repsub_divider.sv
// Sequential unsigned divider that works by repeated subtraction.
// This top level holds the controller FSM (IDLE -> RUN -> DONE). The registers
// and the arithmetic are in repsub_divider_dp.
// Ports:
//   clk, rst    clock; asynchronous active-high reset
//   start       request; sampled only in IDLE
//   dividend    NW-bit operand, captured on the accepted start edge
//   divisor     DW-bit operand, captured on the accepted start edge
//   busy        high whenever the FSM is not in IDLE
//   done        one-cycle pulse; results are valid from this cycle
//   quotient    NW-bit result (shows intermediate counts during RUN)
//   remainder   NW-bit result (shows intermediate values during RUN)
//   dz          divide-by-zero flag for the last operation
//   cycles      RUN-edge counter, saturating; present only with DIVREP_CYCLE_CNT_EN
module repsub_divider
  import divrep_pkg::*;
#(
  parameter int NW = NW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] quotient,
  output logic [NW-1:0] remainder,
  output logic          dz
`ifdef DIVREP_CYCLE_CNT_EN
  ,
  output logic [NW-1:0] cycles
`endif
);

  state_t r_state;
  state_t w_next;
  logic   r_busy;
  logic   r_done;
  logic   w_load;
  logic   w_sub;
  logic   w_inc;
  logic   w_set_dz;
  logic   w_ge_d;
  logic   w_dzero;

  // State register, plus busy/done taken from the next state so that both outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= state_is_busy(w_next);
      r_done  <= (w_next == S_DONE);
    end
  end

  // Next-state and datapath control. A zero divisor takes priority over the compare.
  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_sub    = 1'b0;
    w_inc    = 1'b0;
    w_set_dz = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_dzero) begin
          w_set_dz = 1'b1;
          w_next   = S_DONE;
        end else if (w_ge_d) begin
          w_sub  = 1'b1;
          w_inc  = 1'b1;
          w_next = S_RUN;
        end else begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  repsub_divider_dp #(
    .NW (NW),
    .DW (DW)
  ) u_dp (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_sub       (w_sub),
    .i_inc       (w_inc),
    .i_set_dz    (w_set_dz),
    .i_dividend  (dividend),
    .i_divisor   (divisor),
    .o_quotient  (quotient),
    .o_remainder (remainder),
    .o_dz        (dz),
    .o_ge_d      (w_ge_d),
    .o_dzero     (w_dzero)
  );

  assign busy = r_busy;
  assign done = r_done;

`ifdef DIVREP_CYCLE_CNT_EN
  logic [NW-1:0] r_cycles;

  // Counts RUN edges for the current operation and holds at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycles <= {NW{1'b0}};
    end else if (w_load) begin
      r_cycles <= {NW{1'b0}};
    end else if ((r_state == S_RUN) && (r_cycles != {NW{1'b1}})) begin
      r_cycles <= r_cycles + {{(NW-1){1'b0}}, 1'b1};
    end else begin
      r_cycles <= r_cycles;
    end
  end

  assign cycles = r_cycles;
`endif

endmodule

// File: tb/tb_repsub_divider.sv
module tb_repsub_divider;

  localparam int NW = 16;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic [NW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [NW-1:0] quotient;
  logic [NW-1:0] remainder;
  logic          dz;
`ifdef DIVREP_CYCLE_CNT_EN
  logic [NW-1:0] cycles;
`endif

  int checks = 0;
  int errors = 0;

  repsub_divider #(.NW(NW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz)
`ifdef DIVREP_CYCLE_CNT_EN
    ,
    .cycles    (cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NW-1:0] dvd;
    logic [DW-1:0] dvs;
    logic [NW-1:0] q;
    logic [NW-1:0] r;
    logic          z;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention.
  task automatic model(input int dvd, input int dvs, output int q, output int r,
                       output int z, output int lat);
    if (dvs == 0) begin
      q = 65535; r = dvd; z = 1; lat = 1;
    end else begin
      q = dvd / dvs; r = dvd % dvs; z = 0; lat = q + 1;
    end
  endtask

  // Call on the negedge that follows the accepted start edge. Counts RUN edges
  // until done, optionally pulsing start with other operands at inj_at.
  task automatic wait_done(input string name, input int exp_q, input int exp_r,
                           input int exp_z, input int exp_lat, input int inj_at);
    int n = 0;
    while (!done && n < 70000) begin
      if (inj_at > 0 && n == inj_at) begin
        start = 1'b1; dividend = 16'd50; divisor = 8'd5;
      end
      if (inj_at > 0 && n == inj_at + 1) start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({name, ".latency"}, n, exp_lat);
    chk({name, ".q"}, quotient, exp_q);
    chk({name, ".r"}, remainder, exp_r);
    chk({name, ".dz"}, dz, exp_z);
    chk({name, ".busy_at_done"}, busy, 1);
`ifdef DIVREP_CYCLE_CNT_EN
    chk({name, ".cycles"}, cycles, (exp_lat > 65535) ? 65535 : exp_lat);
`endif
    @(negedge clk);
    chk({name, ".done_pulse"}, done, 0);
    chk({name, ".idle"}, busy, 0);
    chk({name, ".q_held"}, quotient, exp_q);
  endtask

  task automatic launch(input int dvd, input int dvs);
    start = 1'b1;
    dividend = dvd[NW-1:0];
    divisor = dvs[DW-1:0];
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input int dvd, input int dvs);
    int q, r, z, lat;
    model(dvd, dvs, q, r, z, lat);
    launch(dvd, dvs);
    chk({name, ".busy_run"}, busy, 1);
    wait_done(name, q, r, z, lat, 0);
  endtask

  initial begin
    int q, r, z, lat;
    rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #1 rst = 1'b1;
    #2;
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.q", quotient, 0);
    chk("reset.r", remainder, 0);
    chk("reset.dz", dz, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    vecs[0] = '{dvd: 16'd100,   dvs: 8'd7,   q: 16'd14,    r: 16'd2,    z: 1'b0};
    vecs[1] = '{dvd: 16'd5,     dvs: 8'd9,   q: 16'd0,     r: 16'd5,    z: 1'b0};
    vecs[2] = '{dvd: 16'd0,     dvs: 8'd3,   q: 16'd0,     r: 16'd0,    z: 1'b0};
    vecs[3] = '{dvd: 16'd1234,  dvs: 8'd0,   q: 16'hFFFF,  r: 16'd1234, z: 1'b1};
    vecs[4] = '{dvd: 16'd255,   dvs: 8'd255, q: 16'd1,     r: 16'd0,    z: 1'b0};
    vecs[5] = '{dvd: 16'hFFFF,  dvs: 8'd1,   q: 16'hFFFF,  r: 16'd0,    z: 1'b0};

    for (int i = 0; i < 6; i++) begin
      launch(int'(vecs[i].dvd), int'(vecs[i].dvs));
      lat = vecs[i].z ? 1 : int'(vecs[i].q) + 1;
      wait_done($sformatf("vec%0d", i), int'(vecs[i].q), int'(vecs[i].r),
                int'(vecs[i].z), lat, 0);
    end

    // Start pulse while busy must be ignored.
    launch(200, 10);
    wait_done("ignore_start", 20, 0, 0, 21, 3);

    // Start held through DONE: the next operation is accepted in the following IDLE cycle.
    start = 1'b1; dividend = 16'd20; divisor = 8'd5;
    @(negedge clk);
    while (!done) @(negedge clk);
    chk("held.q1", quotient, 4);
    dividend = 16'd9; divisor = 8'd2;
    @(negedge clk);
    chk("held.idle_gap", busy, 0);
    @(negedge clk);
    start = 1'b0;
    chk("held.accepted", busy, 1);
    wait_done("held2", 4, 1, 0, 5, 0);

    // Asynchronous reset in the middle of RUN.
    launch(1000, 3);
    repeat (10) @(negedge clk);
    chk("midrun.busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrun.busy", busy, 0);
    chk("midrun.done", done, 0);
    chk("midrun.q", quotient, 0);
    chk("midrun.r", remainder, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("after_rst", 9, 4);

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      int a, b;
      a = $urandom_range(0, 2047);
      b = (i % 6 == 5) ? 0 : $urandom_range(8, 255);
      model(a, b, q, r, z, lat);
      launch(a, b);
      wait_done($sformatf("rand%0d_%0d_%0d", i, a, b), q, r, z, lat, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
